// File: rtl/jtag_host_ctrl.sv
// jtag_host_ctrl: turns sys_clk-domain commands into complete JTAG TAP walks (TLR, IR/DR scan, idle clocks)
// and returns the captured TDO bits; the TAP is parked in Run-Test/Idle between commands.
module jtag_host_ctrl #(
   parameter int CLK_DIV = 2,
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               sys_clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               rsp_err,
   output logic               busy,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   output logic               trst,
   input  logic               tdo
);
   localparam int IW = LEN_W + 1;
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam logic [1:0] OP_TLR = 2'd0, OP_SIR = 2'd1, OP_SDR = 2'd2, OP_IDLE = 2'd3;

   typedef enum logic [2:0] {RST_SEQ, READY, WALK_IN, SHIFT, WALK_OUT, DONE} state_t;

   state_t             state, st_n, st_c;
   logic [1:0]         op;
   logic [LEN_W-1:0]   len;
   logic [MAX_LEN-1:0] data, cap;
   logic [IW-1:0]      idx, ntot, nidx, w, lenx, ntot_c;
   logic [DW-1:0]      div;
   logic               arm, boot, err, err_c;
   logic               is_scan, cur_sh, nxt_sh, tms_n, tdi_n, trst_n, last_edge, fin, launch;

   assign busy    = !cmd_ready;
   assign is_scan = op == OP_SIR || op == OP_SDR;
   assign w       = op == OP_SIR ? IW'(4) : op == OP_SDR ? IW'(3) : '0;
   assign lenx    = IW'(len);
   assign nidx    = arm ? '0 : idx + IW'(1);
   assign cur_sh  = is_scan && idx >= w && idx < w + lenx;
   assign nxt_sh  = is_scan && nidx >= w && nidx < w + lenx;

   // TMS for the TCK about to be launched: walk-in, shift (Exit1 on last bit), walk-out 1,0
   assign tms_n = op == OP_TLR  ? nidx < IW'(5) :
                  op == OP_IDLE ? 1'b0 :
                  nidx < w      ? nidx < w - IW'(2) :
                  nxt_sh        ? nidx == w + lenx - IW'(1) :
                                  nidx == w + lenx;
   assign tdi_n  = nxt_sh && |((data >> (nidx - w)) & MAX_LEN'(1));
   assign trst_n = op != OP_TLR || nidx >= IW'(5);
   assign st_n   = op == OP_TLR ? RST_SEQ : op == OP_IDLE ? SHIFT :
                   nidx < w ? WALK_IN : nxt_sh ? SHIFT : WALK_OUT;

   assign err_c  = (cmd_op == OP_SIR || cmd_op == OP_SDR) &&
                   (cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN));
   assign ntot_c = cmd_op == OP_TLR ? IW'(6) : err_c ? '0 :
                   cmd_op == OP_SIR ? IW'(cmd_len) + IW'(6) :
                   cmd_op == OP_SDR ? IW'(cmd_len) + IW'(5) : IW'(cmd_len);
   assign st_c   = cmd_op == OP_TLR ? RST_SEQ : cmd_op == OP_IDLE ? SHIFT : WALK_IN;

   assign last_edge = tck && div == DW'(CLK_DIV - 1);
   assign fin       = !cmd_ready && (arm ? ntot == '0 : last_edge && nidx == ntot);
   assign launch    = !cmd_ready && (arm || last_edge);

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state     <= RST_SEQ;
         op        <= OP_TLR;
         len       <= '0;
         data      <= '0;
         cap       <= '0;
         idx       <= '0;
         ntot      <= IW'(6);
         div       <= '0;
         arm       <= 1'b1;
         boot      <= 1'b1;
         err       <= 1'b0;
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         trst      <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         if (state == DONE) state <= READY;
         if (cmd_valid && cmd_ready) begin
            op        <= cmd_op;
            len       <= cmd_len;
            data      <= cmd_data;
            cap       <= '0;
            ntot      <= ntot_c;
            err       <= err_c;
            state     <= st_c;
            arm       <= 1'b1;
            cmd_ready <= 1'b0;
         end else if (fin) begin
            // the power-up TLR walk completes silently; commands get a response
            state     <= boot ? READY : DONE;
            rsp_valid <= !boot;
            rsp_err   <= err;
            rsp_data  <= cap;
            boot      <= 1'b0;
            arm       <= 1'b0;
            cmd_ready <= 1'b1;
            tck       <= 1'b0;
            tms       <= 1'b0;
            tdi       <= 1'b0;
         end else if (launch) begin
            arm   <= 1'b0;
            idx   <= nidx;
            div   <= '0;
            tck   <= 1'b0;
            tms   <= tms_n;
            tdi   <= tdi_n;
            trst  <= trst_n;
            state <= st_n;
         end else if (!cmd_ready) begin
            div <= div + DW'(1);
            if (div == DW'(CLK_DIV - 1)) begin
               div <= '0;
               tck <= 1'b1;
               if (cur_sh) cap <= cap | (MAX_LEN'(tdo) << (idx - w));
            end
         end
      end
   end
endmodule
